// File: rtl/memory_pkg.sv
// memory_pkg
// Shared definitions for the memory responder slice.
//   WORD_W           data word width (16 bits)
//   DEFAULT_ADDR_W   default number of word-address bits
//   DEFAULT_LATENCY  default accept-to-response delay in cycles (legal 1..7)
//   state_t          responder FSM states
//   addr_error()     flags misaligned or out-of-range byte addresses
package memory_pkg;

    localparam int WORD_W          = 16;
    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A byte address is bad when it is odd or when any bit above the
    // word-address field is set; high_mask marks those upper bits.
    function automatic logic addr_error(input logic [WORD_W-1:0] addr,
                                        input logic [WORD_W-1:0] high_mask);
        return addr[0] | (|(addr & high_mask));
    endfunction

endpackage

// File: rtl/memory_responder_mem_array.sv
// mem_array
// Single-port word storage: synchronous write, registered read.
// Contents are deliberately not reset.
// Ports:
//   clock     rising-edge clock
//   write_en  write wdata into word addr on this edge
//   read_en   capture word addr into rdata on this edge
//   addr      word address (ADDR_W bits)
//   wdata     write data (WORD_W bits)
//   rdata     registered read data, held until the next read
module mem_array
    import memory_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Read data is captured only on a read so it stays valid for the
    // whole wait/response window of the request that asked for it.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[addr] <= wdata;
        end
        if (read_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Fixed-latency request/response front end for a 16-bit word memory.
// One request may be outstanding; each takes LATENCY edges from
// acceptance to resp_valid, then waits in RESP for resp_ready.
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   req_valid   request present
//   req_ready   request can be accepted this cycle (IDLE only)
//   req_write   1 = write, 0 = read
//   req_addr    byte address, bit 0 must be 0, bits ADDR_W:1 pick the word
//   req_wdata   write data
//   resp_valid  response present (RESP only)
//   resp_ready  initiator consumes the response
//   resp_rdata  read data, echoed write data, or 0 on error
//   resp_err    request was misaligned or out of range
module memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    // Upper address bits that must be zero; empty when ADDR_W fills the word.
    localparam logic [31:0]       HIGH_MASK_WIDE = 32'hFFFF_FFFF << (ADDR_W + 1);
    localparam logic [WORD_W-1:0] HIGH_MASK      = HIGH_MASK_WIDE[WORD_W-1:0];
    localparam logic [2:0]        LAT_LOAD       = 3'(LATENCY - 1);

    state_t            state;
    state_t            next_state;
    logic [2:0]        count;
    logic              running;
    logic              accept;
    logic              req_bad;
    logic [ADDR_W-1:0] word_addr;
    logic              lat_write;
    logic              lat_err;
    logic [WORD_W-1:0] lat_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              wait_done;

    assign req_bad   = addr_error(req_addr, HIGH_MASK);
    assign word_addr = req_addr[ADDR_W:1];
    assign accept    = req_valid && req_ready;
    assign wait_done = (state == WAIT) && (count == 3'd0);

    // Good requests touch storage on the acceptance edge: writes commit
    // immediately and reads snapshot the word as it stood on that edge.
    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock    (clock),
        .write_en (accept && req_write && !req_bad),
        .read_en  (accept && !req_write && !req_bad),
        .addr     (word_addr),
        .wdata    (req_wdata),
        .rdata    (mem_rdata)
    );

    // State register. running holds req_ready low until the first edge
    // after reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = running;
                if (req_valid && running) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (count == 3'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latency counter: loaded with LATENCY-1 on acceptance so that the
    // WAIT->RESP edge lands exactly LATENCY edges after acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 3'd0;
        end else if (accept) begin
            count <= LAT_LOAD;
        end else if (state == WAIT && count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    // Request attributes captured at acceptance; later activity on the
    // req_* lines cannot alter the response in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_err   <= req_bad;
            lat_wdata <= req_wdata;
        end
    end

    // Response registers load once, on entry to RESP, and then hold until
    // the handshake so the initiator sees stable data under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (wait_done) begin
            resp_err <= lat_err;
            if (lat_err) begin
                resp_rdata <= '0;
            end else if (lat_write) begin
                resp_rdata <= lat_wdata;
            end else begin
                resp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Directed self-checking bench for memory_responder (ADDR_W=10, LATENCY=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_memory_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] got_rdata;
    logic        got_err;
    int          got_lat;

    memory_responder #(
        .ADDR_W  (10),
        .LATENCY (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one request, scribbles on the req_* lines after acceptance,
    // and returns on the falling edge where resp_valid is first seen.
    task automatic applyStimulus(input logic write, input logic [15:0] addr,
                                 input logic [15:0] wdata,
                                 output logic [15:0] rdata, output logic err,
                                 output int edges);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("req_ready_wait", 32'(guard < 50), 32'h1);
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clock);
        req_valid = 1'b0;
        req_write = ~write;
        req_addr  = 16'hFFFF;
        req_wdata = 16'hDEAD;
        edges     = 0;
        while (!resp_valid && edges < 20) begin
            @(negedge clock);
            edges++;
        end
        checkOutput("resp_valid_wait", 32'(edges < 20), 32'h1);
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    // Completes the handshake and expects IDLE on the next cycle.
    task automatic completeResponse(input string tag);
        resp_ready = 1'b1;
        @(negedge clock);
        checkOutput({tag, "_resp_valid_drop"}, 32'(resp_valid), 32'h0);
        checkOutput({tag, "_req_ready_back"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        resp_ready = 1'b1;

        // Power-up reset and release timing
        repeat (3) @(negedge clock);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'h0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("release_ready_early", 32'(req_ready), 32'h0);
        @(negedge clock);
        checkOutput("release_ready_one_edge", 32'(req_ready), 32'h1);

        // Write then read back
        applyStimulus(1'b1, 16'h0010, 16'hBEEF, got_rdata, got_err, got_lat);
        checkOutput("wr_rdata", 32'(got_rdata), 32'h0000BEEF);
        checkOutput("wr_err", 32'(got_err), 32'h0);
        checkOutput("wr_latency", 32'(got_lat), 32'd2);
        completeResponse("wr");
        applyStimulus(1'b0, 16'h0010, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("rd_rdata", 32'(got_rdata), 32'h0000BEEF);
        checkOutput("rd_err", 32'(got_err), 32'h0);
        checkOutput("rd_latency", 32'(got_lat), 32'd2);
        completeResponse("rd");

        // Misaligned write must not touch storage
        applyStimulus(1'b1, 16'h0011, 16'h1234, got_rdata, got_err, got_lat);
        checkOutput("mis_err", 32'(got_err), 32'h1);
        checkOutput("mis_rdata", 32'(got_rdata), 32'h0);
        checkOutput("mis_latency", 32'(got_lat), 32'd2);
        completeResponse("mis");
        applyStimulus(1'b0, 16'h0010, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("mis_after_rdata", 32'(got_rdata), 32'h0000BEEF);
        completeResponse("mis_after");

        // Range boundary: 0x0800 is out, 0x07FE is the top word, no aliasing
        applyStimulus(1'b0, 16'h0800, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("oor_err", 32'(got_err), 32'h1);
        checkOutput("oor_rdata", 32'(got_rdata), 32'h0);
        completeResponse("oor");
        applyStimulus(1'b1, 16'h0000, 16'h0001, got_rdata, got_err, got_lat);
        completeResponse("w0");
        applyStimulus(1'b1, 16'h07FE, 16'h1357, got_rdata, got_err, got_lat);
        checkOutput("top_wr_err", 32'(got_err), 32'h0);
        completeResponse("top_wr");
        applyStimulus(1'b0, 16'h07FE, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("top_rd_rdata", 32'(got_rdata), 32'h00001357);
        checkOutput("top_rd_err", 32'(got_err), 32'h0);
        completeResponse("top_rd");
        applyStimulus(1'b0, 16'h0000, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("no_wrap_rdata", 32'(got_rdata), 32'h00000001);
        completeResponse("no_wrap");

        // Backpressure: hold RESP for 5 cycles and poke req_valid meanwhile
        resp_ready = 1'b0;
        applyStimulus(1'b0, 16'h0010, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("bp_rdata", 32'(got_rdata), 32'h0000BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("bp_hold_valid", 32'(resp_valid), 32'h1);
            checkOutput("bp_hold_rdata", 32'(resp_rdata), 32'h0000BEEF);
            checkOutput("bp_hold_ready", 32'(req_ready), 32'h0);
            if (i == 2) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 16'h0010;
                req_wdata = 16'hFFFF;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        completeResponse("bp");
        applyStimulus(1'b0, 16'h0010, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("bp_ignored_rdata", 32'(got_rdata), 32'h0000BEEF);
        completeResponse("bp_after");

        // Asynchronous reset in the middle of a held response
        resp_ready = 1'b0;
        applyStimulus(1'b0, 16'h0010, 16'h0000, got_rdata, got_err, got_lat);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("async_resp_rdata", 32'(resp_rdata), 32'h0);
        checkOutput("async_resp_err", 32'(resp_err), 32'h0);
        checkOutput("async_req_ready", 32'(req_ready), 32'h0);
        @(negedge clock);
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        #1;
        checkOutput("async_release_early", 32'(req_ready), 32'h0);
        @(negedge clock);
        checkOutput("async_release_ready", 32'(req_ready), 32'h1);

        // Reset while WAITing on a write: no response, write stays committed
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hA5A5;
        checkOutput("rw_ready", 32'(req_ready), 32'h1);
        @(negedge clock);
        req_valid = 1'b0;
        checkOutput("rw_in_wait", 32'(req_ready), 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("rw_rst_valid", 32'(resp_valid), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("rw_no_resp", 32'(resp_valid), 32'h0);
        end
        applyStimulus(1'b0, 16'h0020, 16'h0000, got_rdata, got_err, got_lat);
        checkOutput("rw_committed_rdata", 32'(got_rdata), 32'h0000A5A5);
        checkOutput("rw_committed_err", 32'(got_err), 32'h0);
        completeResponse("rw_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
